sram_scan_ctrl: RTL

SRAM_SCAN_CTRL -- requirements
Module: sram_scan_ctrl

---
 rtl/sram_scan_pkg.sv | 40 ++++
 rtl/sram_scan_shreg.sv | 34 +++
 rtl/sram_scan_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_scan_pkg.sv
// Shared types and frame-layout helpers for the scan-driven SRAM access controller.
// Frame layout, MSB first: op | id_sel | seg_id[1:0] | addr | data.
package sram_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_SHIFT_OUT = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   localparam int   HDR_W    = 4;
   localparam int   SEG_W    = 2;
   localparam logic OP_WRITE = 1'b1;
   localparam logic OP_READ  = 1'b0;
   localparam logic ID_IMEM  = 1'b0;
   localparam logic ID_DMEM  = 1'b1;

   function automatic int frame_w(input int addr_w, input int width);
      return HDR_W + addr_w + width;
   endfunction

   function automatic int addr_lsb(input int width);
      return width;
   endfunction

   function automatic int seg_lsb(input int addr_w, input int width);
      return width + addr_w;
   endfunction

   function automatic int id_pos(input int addr_w, input int width);
      return width + addr_w + SEG_W;
   endfunction

   function automatic int op_pos(input int addr_w, input int width);
      return width + addr_w + SEG_W + 1;
   endfunction

endpackage

// File: rtl/sram_scan_shreg.sv
// Parameterized shift register with parallel load; shifts toward the MSB,
// serial data enters at the LSB and leaves from the MSB.
module sram_scan_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         shift_en,
   input  logic         ser_in,
   output logic [W-1:0] q,
   output logic         ser_out
);

   logic [W-1:0] data_r;

   // Load takes priority over shift so a clear can never be lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r <= {W{1'b0}};
      end else if (load) begin
         data_r <= load_data;
      end else if (shift_en) begin
         data_r <= {data_r[W-2:0], ser_in};
      end else begin
         data_r <= data_r;
      end
   end

   assign q       = data_r;
   assign ser_out = data_r[W-1];

endmodule

// File: rtl/sram_scan_ctrl.sv
// Scan-chain driven SRAM access controller: collects a serial command frame,
// issues one SRAM read or write and streams read data back out serially.
module sram_scan_ctrl
   import sram_scan_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_en,
   input  logic              scan_in,
   output logic              scan_out,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   output logic              mem_cen,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic [1:0]        mem_seg_id,
   output logic              mem_id_sel,
   input  logic [WIDTH-1:0]  mem_rdata
);

   localparam int FRAME_W  = frame_w(ADDR_W, WIDTH);
   localparam int ADDR_LSB = addr_lsb(WIDTH);
   localparam int SEG_LSB  = seg_lsb(ADDR_W, WIDTH);
   localparam int ID_POS   = id_pos(ADDR_W, WIDTH);
   localparam int OP_POS   = op_pos(ADDR_W, WIDTH);
   localparam int CNT_W    = $clog2(FRAME_W + 2);
   localparam int SCNT_W   = $clog2(WIDTH + 1);

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_W + 1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(WIDTH - 1);

   state_e              state_r, state_s;
   logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_s;
   logic [SCNT_W-1:0]   shift_cnt_r, shift_cnt_s;
   logic                scan_en_d_r, scan_en_d_s;
   logic                frame_err_r, frame_err_s;
   logic                in_shift_s, in_clr_s, out_load_s, out_shift_s;
   logic [FRAME_W-1:0]  frame_s;
   logic                in_ser_unused_s;
   logic [WIDTH-1:0]    out_q_unused_s;
   logic                out_msb_s;

   logic                busy_r, done_r, cen_r, wen_r, ren_r, id_sel_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [WIDTH-1:0]    wdata_r;
   logic [1:0]          seg_r;
   logic                busy_s, done_s, cen_s, wen_s, ren_s, id_sel_s;
   logic [ADDR_W-1:0]   addr_s;
   logic [WIDTH-1:0]    wdata_s;
   logic [1:0]          seg_s;

   sram_scan_shreg #(.W(FRAME_W)) u_in_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (in_clr_s),
      .load_data ({FRAME_W{1'b0}}),
      .shift_en  (in_shift_s),
      .ser_in    (scan_in),
      .q         (frame_s),
      .ser_out   (in_ser_unused_s)
   );

   sram_scan_shreg #(.W(WIDTH)) u_out_shreg (
      .clk       (clk),
      .rst       (rst),
      .load      (out_load_s),
      .load_data (mem_rdata),
      .shift_en  (out_shift_s),
      .ser_in    (1'b0),
      .q         (out_q_unused_s),
      .ser_out   (out_msb_s)
   );

   // Next-state, frame collection and shift-out sequencing.
   always_comb begin
      state_s     = state_r;
      bit_cnt_s   = {CNT_W{1'b0}};
      shift_cnt_s = shift_cnt_r;
      scan_en_d_s = 1'b0;
      frame_err_s = frame_err_r;
      in_shift_s  = 1'b0;
      in_clr_s    = 1'b0;
      out_load_s  = 1'b0;
      out_shift_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            scan_en_d_s = scan_en;
            if (scan_en) begin
               in_shift_s = 1'b1;
               bit_cnt_s  = (bit_cnt_r == CNT_SAT) ? bit_cnt_r : bit_cnt_r + CNT_W'(1);
            end else if (scan_en_d_r) begin
               // Falling qualifier closes the frame: exact length or it is discarded.
               if (bit_cnt_r == CNT_FULL) begin
                  state_s = ST_ISSUE;
               end else begin
                  frame_err_s = 1'b1;
                  in_clr_s    = 1'b1;
               end
            end else begin
               bit_cnt_s = bit_cnt_r;
            end
         end
         ST_ISSUE: begin
            state_s = (frame_s[OP_POS] == OP_WRITE) ? ST_DONE : ST_CAPTURE;
         end
         ST_CAPTURE: begin
            out_load_s  = 1'b1;
            shift_cnt_s = {SCNT_W{1'b0}};
            state_s     = ST_SHIFT_OUT;
         end
         ST_SHIFT_OUT: begin
            if (scan_en) begin
               out_shift_s = 1'b1;
               if (shift_cnt_r == SCNT_LAST) begin
                  shift_cnt_s = {SCNT_W{1'b0}};
                  state_s     = ST_DONE;
               end else begin
                  shift_cnt_s = shift_cnt_r + SCNT_W'(1);
               end
            end else begin
               out_shift_s = 1'b0;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output values for the state being entered, so outputs can be registered.
   always_comb begin
      busy_s   = 1'b0;
      done_s   = 1'b0;
      cen_s    = 1'b0;
      wen_s    = 1'b0;
      ren_s    = 1'b0;
      id_sel_s = 1'b0;
      addr_s   = {ADDR_W{1'b0}};
      wdata_s  = {WIDTH{1'b0}};
      seg_s    = 2'b00;
      case (state_s)
         ST_ISSUE: begin
            busy_s   = 1'b1;
            cen_s    = 1'b1;
            wen_s    = frame_s[OP_POS];
            ren_s    = ~frame_s[OP_POS];
            id_sel_s = frame_s[ID_POS];
            addr_s   = frame_s[ADDR_LSB +: ADDR_W];
            wdata_s  = frame_s[WIDTH-1:0];
            seg_s    = frame_s[SEG_LSB +: SEG_W];
         end
         ST_CAPTURE: begin
            busy_s   = 1'b1;
            ren_s    = 1'b1;
            id_sel_s = frame_s[ID_POS];
            addr_s   = frame_s[ADDR_LSB +: ADDR_W];
         end
         ST_SHIFT_OUT: begin
            busy_s = 1'b1;
         end
         ST_DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, counters, sticky error and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= {CNT_W{1'b0}};
         shift_cnt_r <= {SCNT_W{1'b0}};
         scan_en_d_r <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         cen_r       <= 1'b0;
         wen_r       <= 1'b0;
         ren_r       <= 1'b0;
         id_sel_r    <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         wdata_r     <= {WIDTH{1'b0}};
         seg_r       <= 2'b00;
      end else begin
         state_r     <= state_s;
         bit_cnt_r   <= bit_cnt_s;
         shift_cnt_r <= shift_cnt_s;
         scan_en_d_r <= scan_en_d_s;
         frame_err_r <= frame_err_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         cen_r       <= cen_s;
         wen_r       <= wen_s;
         ren_r       <= ren_s;
         id_sel_r    <= id_sel_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         seg_r       <= seg_s;
      end
   end

   assign scan_out   = (state_r == ST_SHIFT_OUT) & out_msb_s;
   assign busy       = busy_r;
   assign done       = done_r;
   assign frame_err  = frame_err_r;
   assign mem_cen    = cen_r;
   assign mem_wen    = wen_r;
   assign mem_ren    = ren_r;
   assign mem_addr   = addr_r;
   assign mem_wdata  = wdata_r;
   assign mem_seg_id = seg_r;
   assign mem_id_sel = id_sel_r;

endmodule
